// File: rtl/gemm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gemm_pkg                                                             |
// | Shared constants for the GEMM instruction sequencer: instruction     |
// | field positions, the GEMM opcode, state encoding, default widths.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gemm_pkg;

  // Default widths of the sequencer interface
  localparam int DEF_INS_WIDTH     = 128;
  localparam int DEF_UPC_WIDTH     = 13;
  localparam int DEF_ACC_IDX_WIDTH = 12;
  localparam int DEF_INP_IDX_WIDTH = 12;
  localparam int DEF_WGT_IDX_WIDTH = 11;
  localparam int DEF_PIPE_DEPTH    = 4;

  // Instruction field layout (LSB position and width)
  localparam int OPC_LSB      = 0;
  localparam int OPC_W        = 3;
  localparam int RST_REG_BIT  = 7;
  localparam int UOP_BGN_LSB  = 8;
  localparam int UOP_BGN_W    = 13;
  localparam int UOP_END_LSB  = 21;
  localparam int UOP_END_W    = 14;
  localparam int ITER_OUT_LSB = 35;
  localparam int ITER_IN_LSB  = 49;
  localparam int ITER_W       = 14;
  localparam int DST_FO_LSB   = 63;
  localparam int DST_FI_LSB   = 74;
  localparam int DST_F_W      = 11;
  localparam int SRC_FO_LSB   = 85;
  localparam int SRC_FI_LSB   = 96;
  localparam int SRC_F_W      = 11;
  localparam int WGT_FO_LSB   = 107;
  localparam int WGT_FI_LSB   = 117;
  localparam int WGT_F_W      = 10;

  localparam logic [OPC_W-1:0] OPC_GEMM = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gemm_loop_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gemm_loop_cnt                                                        |
// | One level of the loop nest: loadable counter that steps on en and    |
// | reloads its start value after reaching last. wrap is the carry into  |
// | the next (outer) level.                                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gemm_loop_cnt #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] start,
  input  logic [W-1:0] last,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == last);

  // Counter register: load wins, otherwise step or reload on wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= wrap ? start : count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gemm_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gemm_seq                                                             |
// | GEMM instruction sequencer: accepts one instruction, walks the       |
// | outer/inner/micro-op loop nest issuing one micro-op per cycle, waits |
// | for the pipeline to drain and pulses done.                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gemm_seq
  import gemm_pkg::*;
#(
  parameter int INS_WIDTH     = DEF_INS_WIDTH,
  parameter int UPC_WIDTH     = DEF_UPC_WIDTH,
  parameter int ACC_IDX_WIDTH = DEF_ACC_IDX_WIDTH,
  parameter int INP_IDX_WIDTH = DEF_INP_IDX_WIDTH,
  parameter int WGT_IDX_WIDTH = DEF_WGT_IDX_WIDTH,
  parameter int PIPE_DEPTH    = DEF_PIPE_DEPTH
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     insn_valid,
  output logic                     insn_ready,
  input  logic [INS_WIDTH-1:0]     insn,
  output logic                     uop_valid,
  output logic [UPC_WIDTH-1:0]     upc,
  output logic [ACC_IDX_WIDTH-2:0] dst_offset_out,
  output logic [ACC_IDX_WIDTH-2:0] dst_offset_in,
  output logic [INP_IDX_WIDTH-2:0] src_offset_out,
  output logic [INP_IDX_WIDTH-2:0] src_offset_in,
  output logic [WGT_IDX_WIDTH-2:0] wgt_offset_out,
  output logic [WGT_IDX_WIDTH-2:0] wgt_offset_in,
  output logic                     reset_reg,
  output logic                     busy,
  output logic                     done
);

  localparam int DW  = ACC_IDX_WIDTH - 1;
  localparam int SW  = INP_IDX_WIDTH - 1;
  localparam int WW  = WGT_IDX_WIDTH - 1;
  localparam int CW  = UOP_END_W;
  localparam int DRW = $clog2(PIPE_DEPTH + 1);
  localparam logic [DRW-1:0] DRAIN_LOAD = DRW'(PIPE_DEPTH);

  state_t state, state_nxt;

  // Incoming instruction fields
  logic [OPC_W-1:0]     f_opc;
  logic [UOP_BGN_W-1:0] f_uop_bgn;
  logic [UOP_END_W-1:0] f_uop_end;
  logic [ITER_W-1:0]    f_iter_out, f_iter_in;

  assign f_opc      = insn[OPC_LSB +: OPC_W];
  assign f_uop_bgn  = insn[UOP_BGN_LSB +: UOP_BGN_W];
  assign f_uop_end  = insn[UOP_END_LSB +: UOP_END_W];
  assign f_iter_out = insn[ITER_OUT_LSB +: ITER_W];
  assign f_iter_in  = insn[ITER_IN_LSB +: ITER_W];

  // Latched fields of the active instruction
  logic                 rr_q;
  logic [CW-1:0]        bgn_q, ulast_q;
  logic [ITER_W-1:0]    olast_q, ilast_q;
  logic [DST_F_W-1:0]   dfo_q, dfi_q;
  logic [SRC_F_W-1:0]   sfo_q, sfi_q;
  logic [WGT_F_W-1:0]   wfo_q, wfi_q;

  // Offset accumulators and drain counter
  logic [DW-1:0]  dst_out_q, dst_in_q;
  logic [SW-1:0]  src_out_q, src_in_q;
  logic [WW-1:0]  wgt_out_q, wgt_in_q;
  logic [DRW-1:0] drain_q;

  logic accept, degen, issuing;
  logic upc_wrap, in_wrap, out_wrap;
  logic [CW-1:0]     upc_cnt;
  logic [ITER_W-1:0] in_cnt, out_cnt;

  assign accept  = insn_valid && (state == ST_IDLE);
  assign issuing = (state == ST_ISSUE);
  assign degen   = (f_opc != OPC_GEMM) || (f_iter_out == '0) || (f_iter_in == '0) ||
                   (f_uop_end <= CW'(f_uop_bgn));

  // Instruction bits with no meaning to the sequencer, and the upc counter
  // bit beyond the issued upc width
  logic unused_bits;
  assign unused_bits = ^{insn[RST_REG_BIT-1:OPC_LSB+OPC_W],
                         insn[INS_WIDTH-1:WGT_FI_LSB+WGT_F_W],
                         upc_cnt[CW-1:UPC_WIDTH], in_cnt, out_cnt};

  // Field latch on accept; loop bounds are stored as last-index values
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_q    <= 1'b0;
      bgn_q   <= '0;
      ulast_q <= '0;
      olast_q <= '0;
      ilast_q <= '0;
      dfo_q   <= '0;
      dfi_q   <= '0;
      sfo_q   <= '0;
      sfi_q   <= '0;
      wfo_q   <= '0;
      wfi_q   <= '0;
    end else if (accept) begin
      rr_q    <= insn[RST_REG_BIT];
      bgn_q   <= CW'(f_uop_bgn);
      ulast_q <= f_uop_end - 1'b1;
      olast_q <= f_iter_out - 1'b1;
      ilast_q <= f_iter_in - 1'b1;
      dfo_q   <= insn[DST_FO_LSB +: DST_F_W];
      dfi_q   <= insn[DST_FI_LSB +: DST_F_W];
      sfo_q   <= insn[SRC_FO_LSB +: SRC_F_W];
      sfi_q   <= insn[SRC_FI_LSB +: SRC_F_W];
      wfo_q   <= insn[WGT_FO_LSB +: WGT_F_W];
      wfi_q   <= insn[WGT_FI_LSB +: WGT_F_W];
    end
  end

  gemm_loop_cnt #(.W(CW)) u_upc_cnt (
    .clk(ap_clk), .rst(ap_rst), .load(accept), .load_val(CW'(f_uop_bgn)),
    .start(bgn_q), .last(ulast_q), .en(issuing), .count(upc_cnt), .wrap(upc_wrap)
  );

  gemm_loop_cnt #(.W(ITER_W)) u_in_cnt (
    .clk(ap_clk), .rst(ap_rst), .load(accept), .load_val('0),
    .start('0), .last(ilast_q), .en(upc_wrap), .count(in_cnt), .wrap(in_wrap)
  );

  gemm_loop_cnt #(.W(ITER_W)) u_out_cnt (
    .clk(ap_clk), .rst(ap_rst), .load(accept), .load_val('0),
    .start('0), .last(olast_q), .en(upc_wrap && in_wrap), .count(out_cnt), .wrap(out_wrap)
  );

  // Offset accumulation: inner offsets step per inner pass and clear when
  // the outer index advances, outer offsets step per outer pass
  always_ff @(posedge ap_clk) begin
    if (ap_rst || accept) begin
      dst_out_q <= '0;
      dst_in_q  <= '0;
      src_out_q <= '0;
      src_in_q  <= '0;
      wgt_out_q <= '0;
      wgt_in_q  <= '0;
    end else if (issuing && upc_wrap) begin
      if (in_wrap) begin
        dst_in_q  <= '0;
        src_in_q  <= '0;
        wgt_in_q  <= '0;
        dst_out_q <= dst_out_q + dfo_q;
        src_out_q <= src_out_q + sfo_q;
        wgt_out_q <= wgt_out_q + wfo_q;
      end else begin
        dst_in_q <= dst_in_q + dfi_q;
        src_in_q <= src_in_q + sfi_q;
        wgt_in_q <= wgt_in_q + wfi_q;
      end
    end
  end

  // Drain counter: loaded on the final issue, counts down in DRAIN
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      drain_q <= '0;
    end else if (issuing && out_wrap) begin
      drain_q <= DRAIN_LOAD;
    end else if (state == ST_DRAIN) begin
      drain_q <= drain_q - 1'b1;
    end
  end

  // State register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (insn_valid) state_nxt = degen ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (out_wrap) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_q == DRW'(1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs; issue fields are forced to zero outside ISSUE
  always_comb begin
    insn_ready     = (state == ST_IDLE);
    busy           = (state != ST_IDLE);
    done           = (state == ST_DONE);
    uop_valid      = issuing;
    upc            = '0;
    dst_offset_out = '0;
    dst_offset_in  = '0;
    src_offset_out = '0;
    src_offset_in  = '0;
    wgt_offset_out = '0;
    wgt_offset_in  = '0;
    reset_reg      = 1'b0;
    if (issuing) begin
      upc            = upc_cnt[UPC_WIDTH-1:0];
      dst_offset_out = dst_out_q;
      dst_offset_in  = dst_in_q;
      src_offset_out = src_out_q;
      src_offset_in  = src_in_q;
      wgt_offset_out = wgt_out_q;
      wgt_offset_in  = wgt_in_q;
      reset_reg      = rr_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gemm_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gemm_seq                                                          |
// | Self-checking bench for gemm_seq: directed and random instructions   |
// | compared against a loop-nest reference model.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gemm_seq;

  localparam int PD = 4;

  logic         ap_clk = 1'b0;
  logic         ap_rst;
  logic         insn_valid;
  logic         insn_ready;
  logic [127:0] insn;
  logic         uop_valid;
  logic [12:0]  upc;
  logic [10:0]  dst_offset_out, dst_offset_in, src_offset_out, src_offset_in;
  logic [9:0]   wgt_offset_out, wgt_offset_in;
  logic         reset_reg, busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 ap_clk = ~ap_clk;

  gemm_seq #(
    .INS_WIDTH(128), .UPC_WIDTH(13), .ACC_IDX_WIDTH(12),
    .INP_IDX_WIDTH(12), .WGT_IDX_WIDTH(11), .PIPE_DEPTH(PD)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .insn_valid(insn_valid), .insn_ready(insn_ready),
    .insn(insn), .uop_valid(uop_valid), .upc(upc),
    .dst_offset_out(dst_offset_out), .dst_offset_in(dst_offset_in),
    .src_offset_out(src_offset_out), .src_offset_in(src_offset_in),
    .wgt_offset_out(wgt_offset_out), .wgt_offset_in(wgt_offset_in),
    .reset_reg(reset_reg), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [2:0] opc, input logic rr,
                                      input logic [12:0] bgn, input logic [13:0] uend,
                                      input logic [13:0] io, input logic [13:0] ii,
                                      input logic [10:0] dfo, input logic [10:0] dfi,
                                      input logic [10:0] sfo, input logic [10:0] sfi,
                                      input logic [9:0] wfo, input logic [9:0] wfi);
    logic [127:0] v;
    v          = '0;
    v[2:0]     = opc;
    v[6:3]     = 4'($urandom);
    v[7]       = rr;
    v[20:8]    = bgn;
    v[34:21]   = uend;
    v[48:35]   = io;
    v[62:49]   = ii;
    v[73:63]   = dfo;
    v[84:74]   = dfi;
    v[95:85]   = sfo;
    v[106:96]  = sfi;
    v[116:107] = wfo;
    v[126:117] = wfi;
    v[127]     = 1'($urandom);
    return v;
  endfunction

  // Present an instruction in the current (idle) cycle; it is accepted at the
  // next rising edge, after which the bus is scrambled to show it is ignored.
  task automatic offer(input logic [127:0] ins);
    insn       = ins;
    insn_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    insn_valid = 1'b0;
    insn       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Reference model: walks the loop nest arithmetically from the accept edge
  // and compares every following cycle up to the next ready cycle.
  task automatic expect_run(input logic [127:0] ins, input string tag);
    int opc, rr, bgn, uend, io, ii, dfo, dfi, sfo, sfi, wfo, wfi;
    bit degen;
    opc  = int'(ins[2:0]);    rr   = int'(ins[7]);
    bgn  = int'(ins[20:8]);   uend = int'(ins[34:21]);
    io   = int'(ins[48:35]);  ii   = int'(ins[62:49]);
    dfo  = int'(ins[73:63]);  dfi  = int'(ins[84:74]);
    sfo  = int'(ins[95:85]);  sfi  = int'(ins[106:96]);
    wfo  = int'(ins[116:107]); wfi = int'(ins[126:117]);
    degen = (opc != 2) || (io == 0) || (ii == 0) || (uend <= bgn);
    if (!degen) begin
      for (int o = 0; o < io; o++)
        for (int i = 0; i < ii; i++)
          for (int k = 0; k < uend - bgn; k++) begin
            @(negedge ap_clk);
            check({tag, ":uop_valid"}, 32'(uop_valid), 1);
            check({tag, ":upc"}, 32'(upc), (bgn + k) % 8192);
            check({tag, ":dst_out"}, 32'(dst_offset_out), (o * dfo) % 2048);
            check({tag, ":dst_in"}, 32'(dst_offset_in), (i * dfi) % 2048);
            check({tag, ":src_out"}, 32'(src_offset_out), (o * sfo) % 2048);
            check({tag, ":src_in"}, 32'(src_offset_in), (i * sfi) % 2048);
            check({tag, ":wgt_out"}, 32'(wgt_offset_out), (o * wfo) % 1024);
            check({tag, ":wgt_in"}, 32'(wgt_offset_in), (i * wfi) % 1024);
            check({tag, ":reset_reg"}, 32'(reset_reg), rr);
            check({tag, ":issue_ready"}, 32'(insn_ready), 0);
            check({tag, ":issue_done"}, 32'(done), 0);
          end
      for (int d = 0; d < PD; d++) begin
        @(negedge ap_clk);
        check({tag, ":drain_valid"}, 32'(uop_valid), 0);
        check({tag, ":drain_done"}, 32'(done), 0);
        check({tag, ":drain_busy"}, 32'(busy), 1);
        check({tag, ":drain_zero"}, {19'd0, upc} | 32'(dst_offset_out) | 32'(reset_reg), 0);
      end
    end
    @(negedge ap_clk);
    check({tag, ":done"}, 32'(done), 1);
    check({tag, ":done_valid"}, 32'(uop_valid), 0);
    check({tag, ":done_ready"}, 32'(insn_ready), 0);
    @(negedge ap_clk);
    check({tag, ":ready_again"}, 32'(insn_ready), 1);
    check({tag, ":ready_done"}, 32'(done), 0);
    check({tag, ":ready_busy"}, 32'(busy), 0);
  endtask

  initial begin
    logic [127:0] a, b;
    logic [12:0]  rbgn;
    ap_rst     = 1'b1;
    insn_valid = 1'b0;
    insn       = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;

    // Reset state
    @(negedge ap_clk);
    check("rst:ready", 32'(insn_ready), 1);
    check("rst:others", {19'd0, upc} | 32'(uop_valid) | 32'(busy) | 32'(done) |
          32'(reset_reg) | 32'(dst_offset_out) | 32'(src_offset_in) | 32'(wgt_offset_in), 0);

    // Nominal loop nest
    a = mk(3'b010, 1'b1, 13'd5, 14'd7, 14'd2, 14'd3, 11'd4, 11'd1, 11'd8, 11'd2, 10'd16, 10'd0);
    offer(a);
    expect_run(a, "nominal");

    // Degenerate loop and non-GEMM opcode
    a = mk(3'b010, 1'b0, 13'd5, 14'd7, 14'd2, 14'd0, 11'd4, 11'd1, 11'd8, 11'd2, 10'd16, 10'd3);
    offer(a);
    expect_run(a, "degen_iter");
    a = mk(3'b000, 1'b0, 13'd5, 14'd7, 14'd2, 14'd2, 11'd4, 11'd1, 11'd8, 11'd2, 10'd16, 10'd3);
    offer(a);
    expect_run(a, "non_gemm");
    a = mk(3'b010, 1'b0, 13'd9, 14'd9, 14'd1, 14'd1, 11'd0, 11'd0, 11'd0, 11'd0, 10'd0, 10'd0);
    offer(a);
    expect_run(a, "degen_uop");

    // Back-to-back with insn_valid held high
    a = mk(3'b010, 1'b0, 13'd100, 14'd101, 14'd1, 14'd1, 11'd7, 11'd7, 11'd7, 11'd7, 10'd7, 10'd7);
    b = mk(3'b010, 1'b1, 13'd200, 14'd201, 14'd1, 14'd1, 11'd3, 11'd3, 11'd3, 11'd3, 10'd3, 10'd3);
    insn       = a;
    insn_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    insn = b;
    expect_run(a, "b2b_first");
    @(posedge ap_clk);
    #1;
    insn_valid = 1'b0;
    expect_run(b, "b2b_second");

    // Offset wrap
    a = mk(3'b010, 1'b0, 13'd0, 14'd1, 14'd3, 14'd1, 11'd2047, 11'd0, 11'd0, 11'd0, 10'd0, 10'd0);
    offer(a);
    expect_run(a, "wrap");

    // Reset in the third issue cycle aborts the instruction
    a = mk(3'b010, 1'b1, 13'd40, 14'd41, 14'd2, 14'd2, 11'd1, 11'd1, 11'd1, 11'd1, 10'd1, 10'd1);
    offer(a);
    @(negedge ap_clk);
    check("rstmid:issue1", 32'(uop_valid), 1);
    @(negedge ap_clk);
    check("rstmid:issue2", 32'(uop_valid), 1);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    @(negedge ap_clk);
    check("rstmid:issue3", 32'(uop_valid), 1);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("rstmid:valid", 32'(uop_valid), 0);
    check("rstmid:ready", 32'(insn_ready), 1);
    check("rstmid:busy", 32'(busy), 0);
    for (int c = 0; c < 8; c++) begin
      check("rstmid:no_done", 32'(done), 0);
      check("rstmid:no_issue", 32'(uop_valid), 0);
      @(negedge ap_clk);
    end

    // Reset overrides a same-cycle accept
    a = mk(3'b010, 1'b0, 13'd1, 14'd3, 14'd1, 14'd1, 11'd1, 11'd1, 11'd1, 11'd1, 10'd1, 10'd1);
    insn       = a;
    insn_valid = 1'b1;
    ap_rst     = 1'b1;
    @(posedge ap_clk);
    #1;
    insn_valid = 1'b0;
    ap_rst     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      check("rstacc:ready", 32'(insn_ready), 1);
      check("rstacc:idle", 32'(uop_valid) | 32'(done) | 32'(busy), 0);
    end

    // Random instructions, including upc wrap near the top of the PC range
    for (int n = 0; n < 14; n++) begin
      rbgn = (n % 4 == 3) ? 13'(8190 + $urandom_range(0, 1)) : 13'($urandom);
      a = mk(($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010, 1'($urandom), rbgn,
             14'(rbgn) + 14'($urandom_range(0, 4)),
             14'($urandom_range(0, 3)), 14'($urandom_range(1, 3)),
             11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom),
             10'($urandom), 10'($urandom));
      offer(a);
      expect_run(a, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
